// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: each owner keeps the output for up to its weight in
// back-to-back transfers before the grant rotates. The data path is purely combinational.
module wrr_arbiter #(
  parameter int unsigned NumIn       = 4,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned WeightWidth = 4,
  parameter bit          LockIn      = 1'b1,
  localparam int unsigned IdxWidth   = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  flush_i,
  input  logic [NumIn-1:0][WeightWidth-1:0]     weights_i,
  input  logic [NumIn-1:0]                      req_i,
  output logic [NumIn-1:0]                      gnt_o,
  input  logic [NumIn-1:0][DataWidth-1:0]       data_i,
  output logic                                  req_o,
  input  logic                                  gnt_i,
  output logic [DataWidth-1:0]                  data_o,
  output logic [IdxWidth-1:0]                   idx_o
);

  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumIn - 1);

  logic [IdxWidth-1:0]    owner_q, owner_d;
  logic [WeightWidth-1:0] credit_q, credit_d;
  logic                   lock_q, lock_d;
  logic [IdxWidth-1:0]    lock_idx_q, lock_idx_d;

  logic [IdxWidth-1:0]    w_search_idx;
  logic                   w_search_hit;
  logic [IdxWidth-1:0]    w_sel;
  logic [WeightWidth-1:0] w_sel_weight;
  logic [WeightWidth-1:0] w_eff_weight;
  logic                   w_handshake;
  logic                   w_keep_owner;

  // Cyclic search starting just after the owner and ending on the owner itself.
  always_comb begin
    logic [IdxWidth-1:0] cand;
    cand         = owner_q;
    w_search_idx = owner_q;
    w_search_hit = 1'b0;
    for (int unsigned k = 0; k < NumIn; k++) begin
      cand = (cand == LastIdx) ? '0 : cand + IdxWidth'(1);
      if (!w_search_hit && req_i[cand]) begin
        w_search_hit = 1'b1;
        w_search_idx = cand;
      end
    end
  end

  always_comb begin
    if (lock_q) begin
      w_sel = lock_idx_q;
    end else if (req_i[owner_q] && (credit_q != '0)) begin
      w_sel = owner_q;
    end else begin
      w_sel = w_search_idx;
    end
  end

  assign req_o  = lock_q ? req_i[lock_idx_q] : |req_i;
  assign data_o = data_i[w_sel];
  assign idx_o  = w_sel;

  always_comb begin
    for (int unsigned i = 0; i < NumIn; i++) begin
      gnt_o[i] = gnt_i && req_o && (w_sel == IdxWidth'(i));
    end
  end

  // A zero weight still earns one transfer per turn.
  assign w_sel_weight = weights_i[w_sel];
  assign w_eff_weight = (w_sel_weight == '0) ? WeightWidth'(1) : w_sel_weight;
  assign w_handshake  = req_o && gnt_i;
  assign w_keep_owner = (w_sel == owner_q) && (credit_q != '0);

  always_comb begin
    owner_d    = owner_q;
    credit_d   = credit_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (w_handshake) begin
      lock_d = 1'b0;
      if (w_keep_owner) begin
        credit_d = credit_q - WeightWidth'(1);
      end else begin
        owner_d  = w_sel;
        credit_d = w_eff_weight - WeightWidth'(1);
      end
    end else if (LockIn && req_o) begin
      lock_d     = 1'b1;
      lock_idx_d = w_sel;
    end
    // Flush overrides any same-cycle handshake update but not the outputs.
    if (flush_i) begin
      owner_d  = LastIdx;
      credit_d = '0;
      lock_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q    <= LastIdx;
      credit_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      owner_q    <= owner_d;
      credit_q   <= credit_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Self-checking bench for wrr_arbiter: expected grant orders and payloads are queued as
// stimulus is applied and popped as handshakes appear at the output.
module tb_wrr_arbiter;

  localparam int NumIn = 4;
  localparam int DW    = 32;
  localparam int WW    = 4;
  localparam int IW    = 2;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       flush;
  logic [NumIn-1:0][WW-1:0]   weights;
  logic [NumIn-1:0]           req;
  logic [NumIn-1:0]           gnt_o;
  logic [NumIn-1:0][DW-1:0]   data;
  logic                       req_o;
  logic                       gnt_i;
  logic [DW-1:0]              data_o;
  logic [IW-1:0]              idx_o;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  logic [DW-1:0] pay_q[NumIn][$];

  always #5 clk = ~clk;

  wrr_arbiter #(
    .NumIn      (NumIn),
    .DataWidth  (DW),
    .WeightWidth(WW),
    .LockIn     (1'b1)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .flush_i  (flush),
    .weights_i(weights),
    .req_i    (req),
    .gnt_o    (gnt_o),
    .data_i   (data),
    .req_o    (req_o),
    .gnt_i    (gnt_i),
    .data_o   (data_o),
    .idx_o    (idx_o)
  );

  // A stalled (locked) input must keep requesting and the selection must not move.
  logic          st_v = 1'b0;
  logic [IW-1:0] st_idx = '0;
  always @(negedge clk) begin
    if (rst_n && st_v) begin
      checks++;
      assert (req[st_idx] && (idx_o === st_idx)) else begin
        errors++;
        $display("FAIL lock_hold: req_i=%b idx_o=%0d, required req_i[%0d]=1 and idx_o=%0d",
                 req, idx_o, st_idx, st_idx);
      end
    end
    st_v   <= rst_n && !flush && req_o && !gnt_i;
    st_idx <= idx_o;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fixed_data();
    for (int i = 0; i < NumIn; i++) data[i] = 32'hA000_0000 + 32'(i);
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    flush   = 1'b0;
    req     = '0;
    gnt_i   = 1'b0;
    weights = '0;
    set_fixed_data();
    repeat (2) adv();
    rst_n = 1'b1;
    adv();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (req_o !== 1'b0 || gnt_o !== 4'b0000) begin
      errors++;
      $display("FAIL reset_idle: req_o=%b gnt_o=%b, required 0 and 0000", req_o, gnt_o);
    end
    req   = 4'b1111;
    gnt_i = 1'b1;
    @(negedge clk);
    checks++;
    if (idx_o !== 2'd0 || gnt_o !== 4'b0001 || req_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_first: idx_o=%0d gnt_o=%b req_o=%b, required 0 0001 1",
               idx_o, gnt_o, req_o);
    end
    checks++;
    if (data_o !== 32'hA000_0000) begin
      errors++;
      $display("FAIL reset_data: data_o=%h, required a0000000", data_o);
    end
    req = 4'b0110;
    @(negedge clk);
    checks++;
    if (idx_o !== 2'd1 || gnt_o !== 4'b0010) begin
      errors++;
      $display("FAIL reset_search: idx_o=%0d gnt_o=%b, required 1 0010", idx_o, gnt_o);
    end
    adv();
    req   = '0;
    gnt_i = 1'b0;
    rst_n = 1'b1;
    adv();
  endtask

  task automatic test_weighted();
    int e;
    int budget;
    int cnt[NumIn];
    int total;
    apply_reset();
    for (int i = 0; i < NumIn; i++) weights[i] = WW'(i + 1);
    req   = 4'b1111;
    gnt_i = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NumIn; i++)
        for (int k = 0; k <= i; k++) exp_q.push_back(i);
    budget = 40;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
      if (req_o && gnt_i) begin
        e = exp_q.pop_front();
        checks++;
        if (idx_o !== IW'(e) || gnt_o !== (4'b0001 << e)) begin
          errors++;
          $display("FAIL weighted_order: idx_o=%0d gnt_o=%b, required %0d %b",
                   idx_o, gnt_o, e, 4'b0001 << e);
        end
        checks++;
        if (data_o !== 32'hA000_0000 + 32'(e)) begin
          errors++;
          $display("FAIL weighted_data: data_o=%h, required %h", data_o, 32'hA000_0000 + 32'(e));
        end
      end
      adv();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL weighted_timeout: %0d grants outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    for (int i = 0; i < NumIn; i++) cnt[i] = 0;
    total = 0;
    repeat (1000) begin
      @(negedge clk);
      if (req_o && gnt_i) begin
        cnt[idx_o]++;
        total++;
      end
      adv();
    end
    checks++;
    if (total != 1000) begin
      errors++;
      $display("FAIL weighted_throughput: %0d transfers in 1000 cycles, required 1000", total);
    end
    for (int i = 0; i < NumIn; i++) begin
      checks++;
      if (cnt[i] < 100 * (i + 1) - 10 || cnt[i] > 100 * (i + 1) + 10) begin
        errors++;
        $display("FAIL weighted_share: input %0d got %0d of 1000, required %0d +-10",
                 i, cnt[i], 100 * (i + 1));
      end
    end
    req   = '0;
    gnt_i = 1'b0;
  endtask

  task automatic test_zero_weights();
    int e;
    int budget;
    apply_reset();
    req   = 4'b1111;
    gnt_i = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < NumIn; i++) exp_q.push_back(i);
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
      if (req_o && gnt_i) begin
        e = exp_q.pop_front();
        checks++;
        if (idx_o !== IW'(e) || data_o !== 32'hA000_0000 + 32'(e)) begin
          errors++;
          $display("FAIL zero_weight_rr: idx_o=%0d data_o=%h, required %0d %h",
                   idx_o, data_o, e, 32'hA000_0000 + 32'(e));
        end
      end
      adv();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL zero_weight_timeout: %0d grants outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    req   = '0;
    gnt_i = 1'b0;
  endtask

  task automatic test_single();
    int e;
    apply_reset();
    weights[2] = 4'd3;
    req        = 4'b0100;
    gnt_i      = 1'b1;
    repeat (12) begin
      exp_q.push_back(2);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (req_o !== 1'b1 || idx_o !== IW'(e) || gnt_o !== 4'b0100) begin
        errors++;
        $display("FAIL single_requester: req_o=%b idx_o=%0d gnt_o=%b, required 1 %0d 0100",
                 req_o, idx_o, gnt_o, e);
      end
      adv();
    end
    req   = '0;
    gnt_i = 1'b0;
  endtask

  task automatic test_lock();
    logic [DW-1:0] d0;
    apply_reset();
    req   = 4'b0011;
    gnt_i = 1'b0;
    d0    = data[0];
    for (int c = 0; c < 5; c++) begin
      data[1] = $urandom;
      data[2] = $urandom;
      @(negedge clk);
      checks++;
      if (idx_o !== 2'd0 || data_o !== d0 || gnt_o !== 4'b0000 || req_o !== 1'b1) begin
        errors++;
        $display("FAIL lock_stall: idx_o=%0d data_o=%h gnt_o=%b req_o=%b, required 0 %h 0000 1",
                 idx_o, data_o, gnt_o, req_o, d0);
      end
      adv();
    end
    gnt_i = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt_o !== 4'b0001 || data_o !== d0) begin
      errors++;
      $display("FAIL lock_release: gnt_o=%b data_o=%h, required 0001 %h", gnt_o, data_o, d0);
    end
    adv();
    gnt_i = 1'b0;
    @(negedge clk);
    checks++;
    if (idx_o !== 2'd1 || gnt_o !== 4'b0000) begin
      errors++;
      $display("FAIL lock_one_transfer: idx_o=%0d gnt_o=%b, required 1 0000", idx_o, gnt_o);
    end
    adv();
    gnt_i = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt_o !== 4'b0010) begin
      errors++;
      $display("FAIL lock_next: gnt_o=%b, required 0010", gnt_o);
    end
    adv();
    // A newcomer that the unlocked search would prefer must not steal a locked selection.
    req   = 4'b1000;
    gnt_i = 1'b0;
    @(negedge clk);
    checks++;
    if (idx_o !== 2'd3) begin
      errors++;
      $display("FAIL lock_pick: idx_o=%0d, required 3", idx_o);
    end
    adv();
    req = 4'b1100;
    @(negedge clk);
    checks++;
    if (idx_o !== 2'd3 || data_o !== data[3]) begin
      errors++;
      $display("FAIL lock_newcomer: idx_o=%0d data_o=%h, required 3 %h", idx_o, data_o, data[3]);
    end
    adv();
    gnt_i = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt_o !== 4'b1000) begin
      errors++;
      $display("FAIL lock_newcomer_gnt: gnt_o=%b, required 1000", gnt_o);
    end
    adv();
    req   = '0;
    gnt_i = 1'b0;
  endtask

  task automatic test_flush();
    int seq[10] = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 0};
    int e;
    apply_reset();
    weights[0] = 4'd4;
    weights[1] = 4'd1;
    weights[2] = 4'd1;
    weights[3] = 4'd1;
    req        = 4'b1111;
    gnt_i      = 1'b1;
    for (int c = 0; c < 10; c++) begin
      flush = (c == 1);
      exp_q.push_back(seq[c]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (idx_o !== IW'(e) || gnt_o !== (4'b0001 << e)) begin
        errors++;
        $display("FAIL flush_cycle%0d: idx_o=%0d gnt_o=%b, required %0d %b",
                 c, idx_o, gnt_o, e, 4'b0001 << e);
      end
      adv();
    end
    flush = 1'b0;
    req   = '0;
    gnt_i = 1'b0;
  endtask

  task automatic test_reset_midburst();
    int seq[5] = '{2, 2, 2, 3, 1};
    int e;
    apply_reset();
    weights[2] = 4'd3;
    req        = 4'b0100;
    gnt_i      = 1'b1;
    repeat (2) adv();
    rst_n = 1'b0;
    req   = 4'b1110;
    @(negedge clk);
    checks++;
    if (idx_o !== 2'd1 || gnt_o !== 4'b0010) begin
      errors++;
      $display("FAIL reset_midburst: idx_o=%0d gnt_o=%b, required 1 0010", idx_o, gnt_o);
    end
    #2;
    rst_n = 1'b1;
    adv();
    for (int c = 0; c < 5; c++) begin
      exp_q.push_back(seq[c]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (idx_o !== IW'(e)) begin
        errors++;
        $display("FAIL reset_restart%0d: idx_o=%0d, required %0d", c, idx_o, e);
      end
      adv();
    end
    req   = '0;
    gnt_i = 1'b0;
  endtask

  task automatic test_random();
    logic [NumIn-1:0] granted;
    logic [DW-1:0]    p;
    int               budget;
    int               left;
    apply_reset();
    for (int i = 0; i < NumIn; i++) pay_q[i].delete();
    granted = '0;
    for (int cyc = 0; cyc < 460; cyc++) begin
      req = req & ~granted;
      if (cyc < 400) begin
        for (int i = 0; i < NumIn; i++) begin
          if (!req[i] && $urandom_range(0, 1) == 1) begin
            p       = $urandom;
            data[i] = p;
            pay_q[i].push_back(p);
            req[i]  = 1'b1;
          end
        end
        gnt_i = ($urandom_range(0, 3) != 0);
        if (cyc % 50 == 0)
          for (int i = 0; i < NumIn; i++) weights[i] = WW'($urandom_range(0, 15));
      end else begin
        gnt_i = 1'b1;
      end
      @(negedge clk);
      granted = '0;
      checks++;
      if (req_o !== |req) begin
        errors++;
        $display("FAIL random_req_o: req_o=%b req_i=%b, required %b", req_o, req, |req);
      end
      if (req_o && gnt_i) begin
        granted = 4'b0001 << idx_o;
        checks++;
        if (gnt_o !== granted || req[idx_o] !== 1'b1) begin
          errors++;
          $display("FAIL random_gnt: gnt_o=%b req_i=%b idx_o=%0d, required %b from a requester",
                   gnt_o, req, idx_o, granted);
        end
        checks++;
        if (pay_q[idx_o].size() == 0) begin
          errors++;
          $display("FAIL random_data: input %0d granted with no payload queued", idx_o);
        end else begin
          p = pay_q[idx_o].pop_front();
          if (data_o !== p) begin
            errors++;
            $display("FAIL random_data: data_o=%h, required %h", data_o, p);
          end
        end
      end else begin
        checks++;
        if (gnt_o !== 4'b0000) begin
          errors++;
          $display("FAIL random_no_gnt: gnt_o=%b, required 0000", gnt_o);
        end
      end
      adv();
    end
    req    = req & ~granted;
    budget = 0;
    left   = 0;
    for (int i = 0; i < NumIn; i++) left += pay_q[i].size();
    checks++;
    if (left != 0 || req !== '0) begin
      errors++;
      $display("FAIL random_drain: %0d payloads undelivered req_i=%b, required 0 and 0000",
               left, req);
    end
    req   = '0;
    gnt_i = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    flush   = 1'b0;
    req     = '0;
    gnt_i   = 1'b0;
    weights = '0;
    set_fixed_data();
    test_reset();
    test_weighted();
    test_zero_weights();
    test_single();
    test_lock();
    test_flush();
    test_reset_midburst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
